// File: rtl/enemy_bullet_pkg.sv
// Shared constants and types for the enemy bullet pool.
package enemy_bullet_pkg;
    localparam int COORD_W         = 10;
    localparam int Y_LIMIT_DEF     = 960;
    localparam int MUZZLE_DX_DEF   = 23;
    localparam int MUZZLE_DY_DEF   = 40;
    localparam int FIRE_PERIOD_DEF = 640;

    typedef logic [2:0] slot_idx_t;
endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping around.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] grant,
    output logic          valid
);
    int j;

    // Scan from the far end back toward ptr so the nearest request wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (req[j]) begin
                grant = PW'(j);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/enemy_fire_scheduler.sv
// Periodic round-robin enemy fire into a fixed pool of downward-moving bullet slots.
module enemy_fire_scheduler
    import enemy_bullet_pkg::*;
#(
    parameter int N_SLOTS     = 4,
    parameter int N_ENEMY     = 4,
    parameter int FIRE_PERIOD = FIRE_PERIOD_DEF,
    parameter int MUZZLE_DX   = MUZZLE_DX_DEF,
    parameter int MUZZLE_DY   = MUZZLE_DY_DEF,
    parameter int Y_LIMIT     = Y_LIMIT_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [COORD_W*N_ENEMY-1:0]   enemy_x,
    input  logic [COORD_W*N_ENEMY-1:0]   enemy_y,
    input  logic [N_ENEMY-1:0]           enemy_alive,
    input  logic [N_SLOTS-1:0]           slot_hit,
    output logic [COORD_W*N_SLOTS-1:0]   slot_x,
    output logic [COORD_W*N_SLOTS-1:0]   slot_y,
    output logic [N_SLOTS-1:0]           slot_active,
    output logic                         fire,
    output slot_idx_t                    fire_slot,
    output slot_idx_t                    fire_src,
    output logic                         fire_drop
);
    localparam int TW = $clog2(FIRE_PERIOD + 1);
    localparam int EW = $clog2(N_ENEMY);

    logic [TW-1:0]                        timer;
    logic                                 pending;
    logic [EW-1:0]                        rr_ptr;
    logic [N_SLOTS-1:0][COORD_W-1:0]      sx, sy, ny;
    logic [EW-1:0]                        src;
    logic                                 src_vld;
    slot_idx_t                            free_idx;
    logic                                 free_vld;
    logic                                 launch, wrap, drop;
    logic [COORD_W-1:0]                   spawn_x, spawn_y;

    assign slot_x = sx;
    assign slot_y = sy;

    rr_pick #(.N(N_ENEMY)) u_pick (
        .req   (enemy_alive),
        .ptr   (rr_ptr),
        .grant (src),
        .valid (src_vld)
    );

    // Lowest-index free slot; downward scan lets the lowest index win.
    always_comb begin
        free_vld = 1'b0;
        free_idx = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_vld = 1'b1;
                free_idx = slot_idx_t'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) ny[i] = sy[i] + 1'b1;
    end

    assign launch  = pending && free_vld && src_vld;
    assign wrap    = tick && (timer == TW'(FIRE_PERIOD - 1));
    // A launch this cycle consumes the old request, so the new one is not a drop.
    assign drop    = wrap && pending && !launch;
    assign spawn_x = enemy_x[COORD_W*src +: COORD_W] + COORD_W'(MUZZLE_DX);
    assign spawn_y = enemy_y[COORD_W*src +: COORD_W] + COORD_W'(MUZZLE_DY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer       <= '0;
            pending     <= 1'b0;
            rr_ptr      <= '0;
            sx          <= '0;
            sy          <= '0;
            slot_active <= '0;
            fire        <= 1'b0;
            fire_slot   <= '0;
            fire_src    <= '0;
            fire_drop   <= 1'b0;
        end else begin
            fire      <= launch;
            fire_drop <= drop;
            if (tick) timer <= wrap ? '0 : timer + 1'b1;
            if (wrap)        pending <= 1'b1;
            else if (launch) pending <= 1'b0;
            if (launch) begin
                fire_slot <= free_idx;
                fire_src  <= slot_idx_t'(src);
                rr_ptr    <= (src == EW'(N_ENEMY - 1)) ? '0 : src + 1'b1;
            end
            for (int i = 0; i < N_SLOTS; i++) begin
                if (slot_active[i]) begin
                    if (slot_hit[i]) begin
                        slot_active[i] <= 1'b0;
                    end else if (tick) begin
                        if (ny[i] > COORD_W'(Y_LIMIT)) slot_active[i] <= 1'b0;
                        else                           sy[i] <= ny[i];
                    end
                end else if (launch && free_idx == slot_idx_t'(i)) begin
                    slot_active[i] <= 1'b1;
                    sx[i]          <= spawn_x;
                    sy[i]          <= spawn_y;
                end
            end
        end
    end
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Randomized and directed checks of enemy_fire_scheduler against a behavioural model.
module tb_enemy_fire_scheduler;
    localparam int NS = 4;
    localparam int NE = 4;
    localparam int FP = 8;
    localparam int DX = 23;
    localparam int DY = 40;
    localparam int YL = 960;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            tick = 1'b0;
    logic [10*NE-1:0] enemy_x = '0, enemy_y = '0;
    logic [NE-1:0]   enemy_alive = '0;
    logic [NS-1:0]   slot_hit = '0;
    logic [10*NS-1:0] slot_x, slot_y;
    logic [NS-1:0]   slot_active;
    logic            fire, fire_drop;
    logic [2:0]      fire_slot, fire_src;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model state
    int ex[NE], ey[NE];
    bit m_act[NS];
    int m_x[NS], m_y[NS];
    int m_timer, m_ptr, m_fslot, m_fsrc;
    bit m_pend, m_fire, m_drop;

    enemy_fire_scheduler #(.N_SLOTS(NS), .N_ENEMY(NE), .FIRE_PERIOD(FP)) dut (
        .clk(clk), .rst(rst), .tick(tick), .enemy_x(enemy_x), .enemy_y(enemy_y),
        .enemy_alive(enemy_alive), .slot_hit(slot_hit), .slot_x(slot_x), .slot_y(slot_y),
        .slot_active(slot_active), .fire(fire), .fire_slot(fire_slot), .fire_src(fire_src),
        .fire_drop(fire_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [NS-1:0] m_mask();
        logic [NS-1:0] m;
        for (int i = 0; i < NS; i++) m[i] = m_act[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; end
        m_timer = 0; m_ptr = 0; m_pend = 0; m_fire = 0; m_drop = 0; m_fslot = 0; m_fsrc = 0;
    endtask

    // One clock of the reference behaviour, evaluated from the inputs about to be sampled.
    task automatic model_step();
        int src = -1, slot = -1;
        bit launch, wrap;
        for (int k = 0; k < NE; k++)
            if (src < 0 && enemy_alive[(m_ptr + k) % NE]) src = (m_ptr + k) % NE;
        for (int i = 0; i < NS; i++)
            if (slot < 0 && !m_act[i]) slot = i;
        launch = m_pend && src >= 0 && slot >= 0;
        wrap   = tick && (m_timer == FP - 1);
        m_drop = wrap && m_pend && !launch;
        m_fire = launch;
        if (launch) begin m_fslot = slot; m_fsrc = src; m_ptr = (src + 1) % NE; end
        if (tick) m_timer = wrap ? 0 : m_timer + 1;
        if (wrap) m_pend = 1; else if (launch) m_pend = 0;
        for (int i = 0; i < NS; i++) begin
            if (m_act[i]) begin
                if (slot_hit[i]) m_act[i] = 0;
                else if (tick) begin
                    if ((m_y[i] + 1) % 1024 > YL) m_act[i] = 0;
                    else m_y[i] = (m_y[i] + 1) % 1024;
                end
            end else if (launch && slot == i) begin
                m_act[i] = 1;
                m_x[i] = (ex[src] + DX) % 1024;
                m_y[i] = (ey[src] + DY) % 1024;
            end
        end
    endtask

    task automatic cyc(input bit t, input logic [NS-1:0] hit);
        tick = t;
        slot_hit = hit;
        for (int i = 0; i < NE; i++) begin
            enemy_x[10*i +: 10] = 10'(ex[i]);
            enemy_y[10*i +: 10] = 10'(ey[i]);
        end
        model_step();
        @(posedge clk);
        #1;
        tick = 0;
        slot_hit = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #10;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_checks += 5;
        if (slot_active !== '0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", slot_active); end
        if (fire !== 1'b0 || fire_drop !== 1'b0) begin n_fail++; $display("FAIL reset_fire: got %b/%b expected 0/0", fire, fire_drop); end
        if (slot_x !== '0) begin n_fail++; $display("FAIL reset_x: got %h expected 0", slot_x); end
        if (slot_y !== '0) begin n_fail++; $display("FAIL reset_y: got %h expected 0", slot_y); end
        if (fire_slot !== 3'd0 || fire_src !== 3'd0) begin n_fail++; $display("FAIL reset_idx: got %0d/%0d expected 0/0", fire_slot, fire_src); end
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_fire_timing();
        do_reset();
        for (int i = 0; i < NE; i++) begin ex[i] = 200 + 50 * i; ey[i] = 30 + i; end
        ex[0] = 100; ey[0] = 50;
        enemy_alive = 4'b1111;
        for (int c = 1; c <= 17; c++) begin
            cyc(1, '0);
            n_checks++;
            if (fire !== (c == 9 || c == 17)) begin n_fail++; $display("FAIL fire_timing_c%0d: fire got %b expected %b", c, fire, (c == 9 || c == 17)); end
            if (c == 9) begin
                n_checks++;
                if (fire_src !== 3'd0 || fire_slot !== 3'd0 || slot_x[9:0] !== 10'd123 || slot_y[9:0] !== 10'd90) begin
                    n_fail++;
                    $display("FAIL first_fire: src %0d slot %0d pos (%0d,%0d) expected 0 0 (123,90)", fire_src, fire_slot, slot_x[9:0], slot_y[9:0]);
                end
            end
            if (c == 17) begin
                n_checks++;
                if (fire_src !== 3'd1 || fire_slot !== 3'd1 || slot_x[19:10] !== 10'd273) begin
                    n_fail++;
                    $display("FAIL second_fire: src %0d slot %0d x %0d expected 1 1 273", fire_src, fire_slot, slot_x[19:10]);
                end
            end
        end
    endtask

    task automatic test_field_exit();
        do_reset();
        ex[0] = 300; ey[0] = 915;
        enemy_alive = 4'b0001;
        for (int c = 1; c <= 9; c++) cyc(1, '0);
        n_checks++;
        if (slot_active[0] !== 1'b1 || slot_y[9:0] !== 10'd955) begin n_fail++; $display("FAIL exit_spawn: act %b y %0d expected 1 955", slot_active[0], slot_y[9:0]); end
        for (int k = 1; k <= 6; k++) begin
            cyc(1, '0);
            n_checks++;
            if (slot_active[0] !== (k <= 5)) begin n_fail++; $display("FAIL exit_tick%0d: active got %b expected %b", k, slot_active[0], (k <= 5)); end
            if (k <= 5) begin
                n_checks++;
                if (slot_y[9:0] !== 10'(955 + k)) begin n_fail++; $display("FAIL exit_y%0d: got %0d expected %0d", k, slot_y[9:0], 955 + k); end
            end
        end
    endtask

    task automatic test_pool_full();
        do_reset();
        for (int i = 0; i < NE; i++) begin ex[i] = 10 * i; ey[i] = 5; end
        enemy_alive = 4'b1111;
        for (int c = 1; c <= 40; c++) cyc(1, '0);
        for (int c = 0; c < 3; c++) begin
            cyc(0, '0);
            n_checks++;
            if (fire !== 1'b0 || slot_active !== 4'b1111) begin n_fail++; $display("FAIL pool_hold%0d: fire %b active %b expected 0 1111", c, fire, slot_active); end
        end
        cyc(0, 4'b0100);
        n_checks++;
        if (fire !== 1'b0 || slot_active !== 4'b1011) begin n_fail++; $display("FAIL pool_retire: fire %b active %b expected 0 1011", fire, slot_active); end
        cyc(0, '0);
        n_checks++;
        if (fire !== 1'b1 || fire_slot !== 3'd2 || slot_active !== 4'b1111 || slot_x[29:20] !== 10'(m_x[2])) begin
            n_fail++;
            $display("FAIL pool_refill: fire %b slot %0d active %b x %0d expected 1 2 1111 %0d", fire, fire_slot, slot_active, slot_x[29:20], m_x[2]);
        end
    endtask

    task automatic test_rr_skip();
        int fires = 0, drops = 0;
        int exp_src[3] = '{1, 3, 1};
        do_reset();
        for (int i = 0; i < NE; i++) begin ex[i] = 40 * i; ey[i] = 0; end
        enemy_alive = 4'b1010;
        for (int c = 1; c <= 25; c++) begin
            cyc(1, '0);
            if (fire === 1'b1) begin
                n_checks++;
                if (fires > 2 || fire_src !== 3'(exp_src[fires])) begin n_fail++; $display("FAIL rr_src%0d: got %0d expected %0d", fires, fire_src, exp_src[fires % 3]); end
                fires++;
            end
        end
        n_checks++;
        if (fires != 3) begin n_fail++; $display("FAIL rr_count: got %0d expected 3", fires); end
        enemy_alive = 4'b0000;
        for (int c = 26; c <= 41; c++) begin
            cyc(1, '0);
            n_checks++;
            if (fire !== 1'b0 || fire_drop !== (c == 40)) begin n_fail++; $display("FAIL rr_dead_c%0d: fire %b drop %b expected 0 %b", c, fire, fire_drop, (c == 40)); end
            if (fire_drop === 1'b1) drops++;
        end
        n_checks++;
        if (drops != 1) begin n_fail++; $display("FAIL rr_drops: got %0d expected 1", drops); end
    endtask

    task automatic test_hit_tick();
        do_reset();
        ex[0] = 77; ey[0] = 152;
        enemy_alive = 4'b0001;
        for (int c = 1; c <= 8; c++) cyc(1, '0);
        cyc(0, '0);
        for (int c = 0; c < 8; c++) cyc(1, '0);
        n_checks++;
        if (slot_y[9:0] !== 10'd200 || slot_active[0] !== 1'b1) begin n_fail++; $display("FAIL hit_pre: y %0d act %b expected 200 1", slot_y[9:0], slot_active[0]); end
        cyc(1, 4'b0001);
        n_checks++;
        if (slot_active !== 4'b0010 || slot_y[9:0] !== 10'd200) begin n_fail++; $display("FAIL hit_tick: active %b y %0d expected 0010 200", slot_active, slot_y[9:0]); end
        n_checks++;
        if (fire !== 1'b1 || fire_slot !== 3'd1) begin n_fail++; $display("FAIL hit_launch: fire %b slot %0d expected 1 1", fire, fire_slot); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < NE; i++) begin ex[i] = 100 + i; ey[i] = 100; end
        enemy_alive = 4'b1111;
        for (int c = 1; c <= 25; c++) cyc(1, '0);
        n_checks++;
        if (slot_active !== 4'b0111) begin n_fail++; $display("FAIL areset_pre: got %b expected 0111", slot_active); end
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (slot_active !== '0 || fire !== 1'b0) begin n_fail++; $display("FAIL areset_now: active %b fire %b expected 0 0", slot_active, fire); end
        @(posedge clk); #1;
        model_reset();
        rst = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            cyc(1, '0);
            n_checks++;
            if (fire !== (c == 9)) begin n_fail++; $display("FAIL areset_c%0d: fire got %b expected %b", c, fire, (c == 9)); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) begin
                for (int i = 0; i < NE; i++) begin ex[i] = $urandom_range(1023); ey[i] = $urandom_range(1023); end
                enemy_alive = 4'($urandom_range(15));
            end
            cyc($urandom_range(2) != 0, ($urandom_range(9) == 0) ? 4'($urandom_range(15)) : 4'b0);
            n_checks += 2;
            if (slot_active !== m_mask()) begin n_fail++; $display("FAIL rnd_active_c%0d: got %b expected %b", c, slot_active, m_mask()); end
            if (fire !== m_fire || fire_drop !== m_drop) begin n_fail++; $display("FAIL rnd_fire_c%0d: fire %b drop %b expected %b %b", c, fire, fire_drop, m_fire, m_drop); end
            if (m_fire) begin
                n_checks++;
                if (fire_slot !== 3'(m_fslot) || fire_src !== 3'(m_fsrc)) begin n_fail++; $display("FAIL rnd_idx_c%0d: slot %0d src %0d expected %0d %0d", c, fire_slot, fire_src, m_fslot, m_fsrc); end
            end
            for (int i = 0; i < NS; i++) begin
                if (m_act[i]) begin
                    n_checks++;
                    if (slot_x[10*i +: 10] !== 10'(m_x[i]) || slot_y[10*i +: 10] !== 10'(m_y[i])) begin
                        n_fail++;
                        $display("FAIL rnd_pos_c%0d_s%0d: (%0d,%0d) expected (%0d,%0d)", c, i, slot_x[10*i +: 10], slot_y[10*i +: 10], m_x[i], m_y[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        model_reset();
        for (int i = 0; i < NE; i++) begin ex[i] = 0; ey[i] = 0; end
        test_reset();
        test_fire_timing();
        test_field_exit();
        test_pool_full();
        test_rr_skip();
        test_hit_tick();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
